// File: rtl/mult_booth.sv
// mult_booth: sequential signed multiplier, radix-2 Booth, one step per clock.
// Produces the 2*WIDTH-bit product split into himult (upper) and lomult (lower).
// Optional feature macro: MULT_EARLY_EXIT_EN. When it is defined, the multiplier
// finishes early once every remaining multiplier bit is identical, because the
// remaining Booth steps would only shift.
module mult_booth #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] himult,
  output logic [WIDTH-1:0] lomult,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH:0]   mcand;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qreg;
  logic             qlsb;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   stepSum;

  // Add or subtract the sign-extended multiplicand according to the Booth pair
  always_comb begin
    stepSum = acc;
    case ({qreg[0], qlsb})
      2'b01:   stepSum = acc + mcand;
      2'b10:   stepSum = acc - mcand;
      default: stepSum = acc;
    endcase
  end

`ifdef MULT_EARLY_EXIT_EN
  logic [WIDTH-1:0]        remMask;
  logic                    remUniform;
  logic [SW-1:0]           remSteps;
  logic signed [2*WIDTH:0] pairShifted;

  // Detect that the unprocessed multiplier bits are all equal, and precompute
  // the collapsed sequence of pure arithmetic shifts that would follow
  always_comb begin
    remMask     = {WIDTH{1'b1}} >> count;
    remUniform  = (((qreg & remMask) == '0) && !qlsb) ||
                  (((qreg & remMask) == remMask) && qlsb);
    remSteps    = SW'(WIDTH) - SW'(count);
    pairShifted = $signed({acc, qreg}) >>> remSteps;
  end
`endif

  // Control FSM and datapath: load operands, iterate Booth steps, publish product
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      mcand  <= '0;
      acc    <= '0;
      qreg   <= '0;
      qlsb   <= 1'b0;
      count  <= '0;
      himult <= '0;
      lomult <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= {A[WIDTH-1], A};
            acc   <= '0;
            qreg  <= B;
            qlsb  <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
`ifdef MULT_EARLY_EXIT_EN
          if (remUniform) begin
            acc   <= pairShifted[2*WIDTH:WIDTH];
            qreg  <= pairShifted[WIDTH-1:0];
            state <= S_DONE;
          end else begin
            acc   <= {stepSum[WIDTH], stepSum[WIDTH:1]};
            qreg  <= {stepSum[0], qreg[WIDTH-1:1]};
            qlsb  <= qreg[0];
            count <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
              state <= S_DONE;
            end
          end
`else
          acc   <= {stepSum[WIDTH], stepSum[WIDTH:1]};
          qreg  <= {stepSum[0], qreg[WIDTH-1:1]};
          qlsb  <= qreg[0];
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          himult <= acc[WIDTH-1:0];
          lomult <= qreg;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth.sv
// tb_mult_booth: self-checking bench for mult_booth (WIDTH=32).
// Products are checked against 64-bit signed arithmetic; latency is derived
// from the multiplier bit pattern (fixed WIDTH+1 unless MULT_EARLY_EXIT_EN).
module tb_mult_booth;
  localparam int WIDTH = 32;

  logic             clock;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] himult;
  logic [WIDTH-1:0] lomult;
  logic             busy;
  logic             done;

  int nCmp  = 0;
  int nFail = 0;

  mult_booth #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .A     (opA),
    .B     (opB),
    .himult(himult),
    .lomult(lomult),
    .busy  (busy),
    .done  (done)
  );

  // Free-running 100 MHz clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case something wedges the simulation
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Full signed product as plain 64-bit arithmetic
  function automatic logic [63:0] model_product(logic [31:0] a, logic [31:0] b);
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  // Cycles from the accepting edge to the edge that raises done
  function automatic int exp_latency(logic [31:0] b);
`ifdef MULT_EARLY_EXIT_EN
    logic prev;
    bit   uni;
    for (int c = 0; c < WIDTH; c++) begin
      prev = (c == 0) ? 1'b0 : b[c-1];
      uni  = 1'b1;
      for (int i = c; i < WIDTH; i++) begin
        if (b[i] !== prev) uni = 1'b0;
      end
      if (uni) return c + 2;
    end
    return WIDTH + 1;
`else
    return WIDTH + 1;
`endif
  endfunction

  // Issue one operation and wait (bounded) for done; no checking here
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output int lat, output bit timedOut, output bit held);
    logic [31:0] hi0, lo0;
    @(posedge clock); #1;
    opA = a; opB = b; start = 1'b1;
    hi0 = himult; lo0 = lomult; held = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; opA = $urandom; opB = $urandom;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (himult !== hi0 || lomult !== lo0 || busy !== 1'b1) held = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    timedOut = (done !== 1'b1);
    hi = himult;
    lo = lomult;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; opA = '0; opB = '0;
    repeat (2) @(posedge clock);
    #1;
    nCmp++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    nCmp++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    nCmp++; if ({himult, lomult} !== 64'd0) begin nFail++; $display("[TB] FAIL reset_product: got %h%h want 0", himult, lomult); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] as [4] = '{32'd6, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bs [4] = '{32'd7, 32'd5,        32'h80000000, 32'hFFFFFFFF};
    logic [63:0] exp;
    logic [31:0] hi, lo;
    int lat;
    bit to, held;
    for (int i = 0; i < 4; i++) begin
      do_mult(as[i], bs[i], hi, lo, lat, to, held);
      exp = model_product(as[i], bs[i]);
      nCmp++; if (to) begin nFail++; $display("[TB] FAIL directed_timeout[%0d]: done not seen", i); end
      nCmp++; if ({hi, lo} !== exp) begin nFail++; $display("[TB] FAIL directed_product[%0d]: got %h%h want %h", i, hi, lo, exp); end
      nCmp++; if (lat != exp_latency(bs[i])) begin nFail++; $display("[TB] FAIL directed_latency[%0d]: got %0d want %0d", i, lat, exp_latency(bs[i])); end
      nCmp++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL directed_busy_at_done[%0d]: got %b want 0", i, busy); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] hi, lo;
    int lat;
    bit to, held, sawDone;
    @(posedge clock); #1;
    opA = 32'd6; opB = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    nCmp++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    nCmp++; if ({himult, lomult} !== 64'd0) begin nFail++; $display("[TB] FAIL abort_product: got %h%h want 0", himult, lomult); end
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done === 1'b1) sawDone = 1'b1;
    end
    nCmp++; if (sawDone) begin nFail++; $display("[TB] FAIL abort_no_done: got done pulse want none"); end
    do_mult(32'd2, 32'd3, hi, lo, lat, to, held);
    nCmp++; if (to) begin nFail++; $display("[TB] FAIL abort_followup_timeout: done not seen"); end
    nCmp++; if ({hi, lo} !== 64'd6) begin nFail++; $display("[TB] FAIL abort_followup_product: got %h%h want 6", hi, lo); end
  endtask

  task automatic test_ignored_start();
    int lat;
    @(posedge clock); #1;
    opA = 32'd6; opB = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; lat = 0;
    repeat (3) begin @(posedge clock); #1; lat++; end
    opA = 32'd9; opB = 32'd9; start = 1'b1;
    @(posedge clock); #1; lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 200) begin @(posedge clock); #1; lat++; end
    nCmp++; if (done !== 1'b1) begin nFail++; $display("[TB] FAIL ignored_timeout: done not seen"); end
    nCmp++; if ({himult, lomult} !== 64'd42) begin nFail++; $display("[TB] FAIL ignored_product: got %h%h want 42", himult, lomult); end
    nCmp++; if (lat != exp_latency(32'd7)) begin nFail++; $display("[TB] FAIL ignored_latency: got %0d want %0d", lat, exp_latency(32'd7)); end
    repeat (3) @(posedge clock);
    #1;
    nCmp++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL ignored_no_queue: busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] got1;
    int lat;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    @(posedge clock); #1;
    opA = a1; opB = b1; start = 1'b1;
    @(posedge clock); #1;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin @(posedge clock); #1; lat++; end
    got1 = {himult, lomult};
    nCmp++; if (got1 !== model_product(a1, b1)) begin nFail++; $display("[TB] FAIL b2b_first: got %h want %h", got1, model_product(a1, b1)); end
    opA = a2; opB = b2;
    @(posedge clock); #1;
    start = 1'b0;
    nCmp++; if (busy !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_restart_busy: got %b want 1", busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin @(posedge clock); #1; lat++; end
    nCmp++; if ({himult, lomult} !== model_product(a2, b2)) begin nFail++; $display("[TB] FAIL b2b_second: got %h%h want %h", himult, lomult, model_product(a2, b2)); end
    nCmp++; if (lat != exp_latency(b2)) begin nFail++; $display("[TB] FAIL b2b_latency: got %0d want %0d", lat, exp_latency(b2)); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, hi, lo;
    logic [63:0] exp;
    int lat;
    bit to, held;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom;
      if (i % 6 == 0) b = 32'd0;
      if (i % 6 == 1) b = 32'hFFFFFFFF;
      if (i % 6 == 2) a = 32'h80000000;
      if (i % 6 == 3) b = 32'h80000000;
      do_mult(a, b, hi, lo, lat, to, held);
      exp = model_product(a, b);
      nCmp++; if (to) begin nFail++; $display("[TB] FAIL rand_timeout[%0d]: done not seen", i); end
      nCmp++; if ({hi, lo} !== exp) begin nFail++; $display("[TB] FAIL rand_product[%0d]: A=%h B=%h got %h%h want %h", i, a, b, hi, lo, exp); end
      nCmp++; if (lat != exp_latency(b)) begin nFail++; $display("[TB] FAIL rand_latency[%0d]: got %0d want %0d", i, lat, exp_latency(b)); end
      nCmp++; if (!held) begin nFail++; $display("[TB] FAIL rand_hold[%0d]: outputs changed or busy dropped during run, want held", i); end
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_ignored_start();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
